// File: rtl/channel_sequencer.sv
// Song-ROM pattern sequencer for one tone channel: fetches 16-bit event words
// and presents note/gate for durations counted in frame ticks, with one loop level.
module channel_sequencer #(
   parameter int ADDR_WIDTH = 6,
   parameter int NOTE_WIDTH = 6
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic                  i_stop,
   input  logic                  i_tick,
   output logic [ADDR_WIDTH-1:0] o_rom_addr,
   input  logic [15:0]           i_rom_data,
   output logic [NOTE_WIDTH-1:0] o_note,
   output logic                  o_gate,
   output logic                  o_note_strobe,
   output logic                  o_playing,
   output logic                  o_done
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_DECODE = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;

   localparam logic [1:0] OP_NOTE = 2'd0;
   localparam logic [1:0] OP_REST = 2'd1;
   localparam logic [1:0] OP_LOOP = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] PC_ONE = 1;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [NOTE_WIDTH-1:0] note_q, note_d;
   logic                  gate_q, gate_d;
   logic                  strobe_q, strobe_d;
   logic                  playing_q, playing_d;
   logic                  done_q, done_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  loop_active_q, loop_active_d;
   logic [3:0]            loop_rem_q, loop_rem_d;

   logic [1:0]            ev_op;
   logic [3:0]            ev_count;
   logic [ADDR_WIDTH-1:0] ev_target;
   logic [7:0]            ev_dur;
   logic [NOTE_WIDTH-1:0] ev_note;

   assign ev_op     = i_rom_data[15:14];
   assign ev_count  = i_rom_data[13:10];
   assign ev_target = i_rom_data[ADDR_WIDTH-1:0];
   assign ev_dur    = i_rom_data[7:0];
   assign ev_note   = i_rom_data[8 +: NOTE_WIDTH];

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      note_d        = note_q;
      gate_d        = gate_q;
      strobe_d      = 1'b0;
      done_d        = 1'b0;
      cnt_d         = cnt_q;
      loop_active_d = loop_active_q;
      loop_rem_d    = loop_rem_q;

      case (state_q)
         S_IDLE: begin
            if (i_start && !i_stop) begin
               pc_d          = '0;
               loop_active_d = 1'b0;
               state_d       = S_FETCH;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            case (ev_op)
               OP_NOTE: begin
                  note_d   = ev_note;
                  gate_d   = 1'b1;
                  strobe_d = 1'b1;
                  cnt_d    = ev_dur;
                  state_d  = S_HOLD;
               end
               OP_REST: begin
                  gate_d  = 1'b0;
                  cnt_d   = ev_dur;
                  state_d = S_HOLD;
               end
               OP_LOOP: begin
                  // Count 0 loops forever regardless of any counted loop in progress.
                  if (ev_count == 4'd0) begin
                     pc_d = ev_target;
                  end else if (!loop_active_q) begin
                     loop_active_d = 1'b1;
                     loop_rem_d    = ev_count - 4'd1;
                     pc_d          = ev_target;
                  end else if (loop_rem_q != 4'd0) begin
                     loop_rem_d = loop_rem_q - 4'd1;
                     pc_d       = ev_target;
                  end else begin
                     loop_active_d = 1'b0;
                     pc_d          = pc_q + PC_ONE;
                  end
                  state_d = S_FETCH;
               end
               default: begin
                  done_d  = 1'b1;
                  gate_d  = 1'b0;
                  state_d = S_IDLE;
               end
            endcase
         end
         default: begin
            // A loaded count of 0 wraps to 255 on the first tick, giving 256 ticks.
            if (i_tick) begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  gate_d  = 1'b0;
                  pc_d    = pc_q + PC_ONE;
                  state_d = S_FETCH;
               end
            end
         end
      endcase

      if (i_stop && (state_q != S_IDLE)) begin
         state_d       = S_IDLE;
         gate_d        = 1'b0;
         loop_active_d = 1'b0;
         strobe_d      = 1'b0;
         done_d        = 1'b0;
      end

      playing_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= S_IDLE;
         pc_q          <= '0;
         note_q        <= '0;
         gate_q        <= 1'b0;
         strobe_q      <= 1'b0;
         playing_q     <= 1'b0;
         done_q        <= 1'b0;
         cnt_q         <= '0;
         loop_active_q <= 1'b0;
         loop_rem_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         note_q        <= note_d;
         gate_q        <= gate_d;
         strobe_q      <= strobe_d;
         playing_q     <= playing_d;
         done_q        <= done_d;
         cnt_q         <= cnt_d;
         loop_active_q <= loop_active_d;
         loop_rem_q    <= loop_rem_d;
      end
   end

   assign o_rom_addr    = pc_q;
   assign o_note        = note_q;
   assign o_gate        = gate_q;
   assign o_note_strobe = strobe_q;
   assign o_playing     = playing_q;
   assign o_done        = done_q;

endmodule
